// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and the decoded M-stage
// memory-op bundle used by the access controller.
package mem_access_ctrl_pkg;

    localparam logic [5:0] op_LB  = 6'b100000;
    localparam logic [5:0] op_LH  = 6'b100001;
    localparam logic [5:0] op_LW  = 6'b100011;
    localparam logic [5:0] op_LBU = 6'b100100;
    localparam logic [5:0] op_LHU = 6'b100101;
    localparam logic [5:0] op_SB  = 6'b101000;
    localparam logic [5:0] op_SH  = 6'b101001;
    localparam logic [5:0] op_SW  = 6'b101011;

    typedef enum logic [1:0] {
        st_IDLE = 2'd0,
        st_ADDR = 2'd1,
        st_DATA = 2'd2,
        st_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        memop;
        logic        load;
        logic        misalign;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } align_t;

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Combinational M-stage decode: memory-op class, alignment fault,
// byte enables and lane-replicated store data.
module mem_access_ctrl_store_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  opM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output align_t      al
);

    always_comb begin
        al = '0;
        unique case (opM)
            op_LW: begin
                al.memop    = 1'b1;
                al.load     = 1'b1;
                al.misalign = |aluoutM[1:0];
            end
            op_LH, op_LHU: begin
                al.memop    = 1'b1;
                al.load     = 1'b1;
                al.misalign = aluoutM[0];
            end
            op_LB, op_LBU: begin
                al.memop = 1'b1;
                al.load  = 1'b1;
            end
            op_SW: begin
                al.memop    = 1'b1;
                al.misalign = |aluoutM[1:0];
                al.wen      = 4'b1111;
                al.wdata    = writedataM;
            end
            op_SH: begin
                al.memop    = 1'b1;
                al.misalign = aluoutM[0];
                al.wen      = aluoutM[1] ? 4'b1100 : 4'b0011;
                al.wdata    = {2{writedataM[15:0]}};
            end
            op_SB: begin
                al.memop = 1'b1;
                al.wen   = 4'b0001 << aluoutM[1:0];
                al.wdata = {4{writedataM[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store sequencer: one outstanding SRAM transaction,
// pipeline stall until DONE, registered raw read word.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        stall_ext,
    output logic        stallM,
    output logic [31:0] readdataM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wen,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    align_t al;
    state_t state;
    state_t state_n;
    logic   go;
    logic   req;

    mem_access_ctrl_store_align u_align (
        .opM        (opM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .al         (al)
    );

    assign go = al.memop & ~al.misalign;

    always_ff @(posedge clk) begin
        if (rst) state <= st_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst)
            readdataM <= '0;
        else if (state == st_DATA && data_data_ok && al.load)
            readdataM <= data_rdata;
    end

    always_comb begin
        state_n = state;
        req     = 1'b0;
        unique case (state)
            st_IDLE: begin
                req = go;
                if (go && data_addr_ok) state_n = st_DATA;
                else if (go)            state_n = st_ADDR;
            end
            st_ADDR: begin
                req = 1'b1;
                if (data_addr_ok) state_n = st_DATA;
            end
            st_DATA: begin
                if (data_data_ok) state_n = st_DATA == state ? st_DONE : state;
            end
            st_DONE: begin
                // hold here so a frozen M stage cannot re-issue itself
                if (!stall_ext) state_n = st_IDLE;
            end
        endcase
    end

    assign data_req   = req & ~rst;
    assign stallM     = go & (state != st_DONE) & ~rst;
    assign adelM      = al.misalign & al.load & ~rst;
    assign adesM      = al.misalign & al.memop & ~al.load & ~rst;
    assign data_wr    = al.memop & ~al.load & ~rst;
    assign data_wen   = rst ? 4'b0 : al.wen;
    assign data_addr  = rst ? 32'b0 : aluoutM;
    assign data_wdata = rst ? 32'b0 : al.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: stimulus plays pipeline and SRAM, a negedge monitor
// checks every request handshake and every completed load.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam logic [5:0] OP_NONE = 6'b001000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opM;
    logic [31:0] aluoutM, writedataM;
    logic        stall_ext;
    logic        stallM;
    logic [31:0] readdataM;
    logic        adelM, adesM;
    logic        data_req, data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opM          (opM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .stall_ext    (stall_ext),
        .stallM       (stallM),
        .readdataM    (readdataM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rd[$];
    int checks = 0, failures = 0;
    int hs_cnt = 0, req_cycles = 0, issued = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Reference: access size in bytes, offset within the word,
    // enables cover [off, off+size), each lane gets byte (lane % size).
    function automatic void model(
        input  logic [5:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic        go,
        output logic        ld,
        output logic        mis,
        output logic [3:0]  wen,
        output logic [31:0] wdata);
        int size, off;
        logic mem;
        mem = 1'b1; ld = 1'b0; size = 1;
        case (op)
            op_LW:         begin size = 4; ld = 1'b1; end
            op_LH, op_LHU: begin size = 2; ld = 1'b1; end
            op_LB, op_LBU: begin size = 1; ld = 1'b1; end
            op_SW:         size = 4;
            op_SH:         size = 2;
            op_SB:         size = 1;
            default:       mem = 1'b0;
        endcase
        off   = int'(a[1:0]);
        mis   = mem && (off % size != 0);
        go    = mem && !mis;
        wen   = 4'b0;
        wdata = 32'b0;
        if (mem && !ld)
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) wen[i] = 1'b1;
                wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
    endfunction

    logic        rd_arm = 1'b0;
    logic [31:0] rd_want;

    always @(negedge clk) begin
        req_t e;
        if (rd_arm) begin
            chk("readdata", readdataM, rd_want);
            chk("done_stall", {31'b0, stallM}, 32'd0);
            rd_arm = 1'b0;
        end
        if (!rst) begin
            if (data_req) req_cycles++;
            if (exp_req.size() == 0)
                chk("no_req", {31'b0, data_req}, 32'd0);
            else if (data_req && data_addr_ok) begin
                e = exp_req.pop_front();
                hs_cnt++;
                chk("req_addr", data_addr, e.addr);
                chk("req_wr", {31'b0, data_wr}, {31'b0, e.wr});
                chk("req_wen", {28'b0, data_wen}, {28'b0, e.wen});
                if (e.wr) chk("req_wdata", data_wdata, e.wdata);
            end
            if (data_data_ok && exp_rd.size() != 0) begin
                rd_want = exp_rd.pop_front();
                rd_arm  = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input int al, input int dl,
                         input int el, input logic [31:0] rd);
        logic go, ld, mis;
        logic [3:0]  wen;
        logic [31:0] wdat;
        req_t r;
        int rc0;
        model(op, a, wd, go, ld, mis, wen, wdat);
        opM = op; aluoutM = a; writedataM = wd;
        if (!go) begin
            @(negedge clk);
            chk("adelM", {31'b0, adelM}, {31'b0, mis && ld});
            chk("adesM", {31'b0, adesM}, {31'b0, mis && !ld});
            chk("nogo_req", {31'b0, data_req}, 32'd0);
            chk("nogo_stall", {31'b0, stallM}, 32'd0);
            step();
            opM = OP_NONE;
            return;
        end
        rc0 = req_cycles;
        r = '{a, !ld, wen, wdat};
        exp_req.push_back(r);
        issued++;
        for (int i = 0; i <= al; i++) begin
            data_addr_ok = (i == al);
            stall_ext = 1'($urandom % 2);
            @(negedge clk);
            chk("stall_addr", {31'b0, stallM}, 32'd1);
            if (i == 0) chk("go_flags", {30'b0, adelM, adesM}, 32'd0);
            step();
        end
        data_addr_ok = 1'b0;
        for (int j = 1; j <= dl; j++) begin
            data_data_ok = (j == dl);
            data_rdata = (j == dl) ? rd : $urandom;
            stall_ext = 1'($urandom % 2);
            if (j == dl && ld) exp_rd.push_back(rd);
            @(negedge clk);
            chk("stall_data", {31'b0, stallM}, 32'd1);
            step();
        end
        data_data_ok = 1'b0;
        for (int k = 0; k <= el; k++) begin
            stall_ext = (k < el);
            @(negedge clk);
            chk("stall_done", {31'b0, stallM}, 32'd0);
            step();
        end
        stall_ext = 1'b0;
        chk("req_cycles", req_cycles - rc0, al + 1);
        opM = OP_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [9];
        ops = '{op_LW, op_LB, op_LBU, op_LH, op_LHU,
                op_SW, op_SB, op_SH, OP_NONE};
        rst = 1'b1; opM = op_LH; aluoutM = 32'h101;
        writedataM = 32'hFFFF_FFFF; stall_ext = 1'b0;
        data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        chk("rst_req", {31'b0, data_req}, 32'd0);
        chk("rst_stall", {31'b0, stallM}, 32'd0);
        chk("rst_adel", {31'b0, adelM}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        step(); step();
        chk("rst_rd", readdataM, 32'd0);
        rst = 1'b0; opM = OP_NONE; data_addr_ok = 1'b0;
        step();

        do_op(op_LW, 32'h100, 32'h0, 0, 1, 0, 32'hDEADBEEF);
        chk("lw_hold", readdataM, 32'hDEADBEEF);
        do_op(op_SB, 32'h203, 32'h12345678, 3, 1, 0, 32'h0);
        chk("rd_hold_store", readdataM, 32'hDEADBEEF);
        do_op(op_SH, 32'h202, 32'h12345678, 1, 2, 0, 32'h0);
        do_op(op_LH, 32'h101, 32'h0, 0, 1, 0, 32'h0);
        do_op(op_SW, 32'h102, 32'h55, 0, 1, 0, 32'h0);
        do_op(op_LW, 32'h104, 32'h0, 0, 1, 2, 32'hCAFEF00D);
        chk("rd_after_stall", readdataM, 32'hCAFEF00D);

        for (int n = 0; n < 60; n++)
            do_op(ops[$urandom % 9], $urandom, $urandom,
                  int'($urandom % 4), 1 + int'($urandom % 3),
                  int'($urandom % 3), $urandom);

        opM = op_LW; aluoutM = 32'h300; data_addr_ok = 1'b1;
        exp_req.push_back('{32'h300, 1'b0, 4'b0, 32'h0});
        issued++;
        step();
        data_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", {31'b0, data_req}, 32'd0);
        step();
        rst = 1'b0; opM = OP_NONE;
        data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("stale_req", {31'b0, data_req}, 32'd0);
        step();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("stale_rd", readdataM, 32'd0);
        step();
        do_op(op_LBU, 32'h401, 32'h0, 2, 1, 1, 32'h0A0B0C0D);

        step(); step();
        chk("handshakes", hs_cnt, issued);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
